control_sequencer: RTL and testbench
====================================

CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 SHALL have port `clock`, input, 1 bit: single system clock; all state changes occur on its rising edge.
REQ-002 SHALL have port `clear`, input, 1 bit: reset, asynchronous and active-low.
REQ-003 SHALL have port `IR`, input, 32 bits: instruction register contents from the datapath; opcode = IR[31:27].
REQ-004 SHALL have port `Stop`, input, 1 bit: external halt request.
REQ-005 SHALL have outputs `PCout`, `IncPC`, `PCin`, `MARin`, `Zin`, `Zlowout`, `Zhighout`, `Read`, `MDRin`, `MDRout`, `IRin`, `Yin`, `LOin`, `HIin`, each 1 bit: datapath control strobes.
REQ-006 SHALL have outputs `Gra`, `Grb`, `Grc`, `Rin`, `Rout`, each 1 bit: register-field select and general-register in/out enables.
REQ-007 SHALL have port `ALUop`, output, 5 bits: ALU operation code, 0 when no ALU step is active.
REQ-008 SHALL have port `Run`, output, 1 bit: 1 while the sequencer is executing instructions.

Function
REQ-009 SHALL be a Moore machine: every output is decoded from the registered state and latched opcode only, so outputs change only after a rising `clock` edge or on reset.
REQ-010 SHALL implement these states: RST, T0, T1, T2, T3, T4, T5, T6, HALT.
REQ-011 SHALL drive, in RST: all outputs 0; RST goes to T0 on the first rising edge with `clear`=1.
REQ-012 SHALL drive, in T0: PCout, IncPC, Zin, MARin = 1.
REQ-013 SHALL drive, in T1: Zlowout, PCin, Read, MDRin = 1.
REQ-014 SHALL drive, in T2: MDRout, IRin = 1.
REQ-015 SHALL latch IR[31:27] into an internal opcode register at the end of T2; T3 onward decode from the latched value.
REQ-016 SHALL support these opcodes: add 00011, sub 00100, shr 00101, shl 00110, ror 00111, rol 01000, and 01001, or 01010, mul 01110, div 01111, neg 10000, not 10001, nop 11000, halt 11001.
REQ-017 SHALL sequence binary ops (add..or) as: T3 Grb, Rout, Yin; T4 Grc, Rout, Zin, ALUop=opcode; T5 Zlowout, Gra, Rin; then end of instruction.
REQ-018 SHALL sequence mul/div as: T3 and T4 as in REQ-017; T5 Zlowout, LOin; T6 Zhighout, HIin; then end of instruction.
REQ-019 SHALL sequence neg/not as: T3 Grb, Rout, Zin, ALUop=opcode; T4 Zlowout, Gra, Rin; then end of instruction.
REQ-020 SHALL end nop and any undefined opcode after T2, with no execute-step strobes.
REQ-021 SHALL go from T2 to HALT for the halt opcode.
REQ-022 SHALL, at end of instruction, go to HALT if `Stop`=1 is sampled on that edge; otherwise go to T0.
REQ-023 SHALL hold HALT, with all strobes 0 and Run=0, until reset.
REQ-024 SHALL drive Run=1 in T0..T6 and Run=0 in RST and HALT.
REQ-025 SHALL assert at most one of Gra/Grb/Grc in any state, and SHALL NOT assert Rin and Rout together.
REQ-026 SHALL ignore `Stop` outside the end-of-instruction edge.

Reset
REQ-027 SHALL, on `clear`=0, enter RST immediately without waiting for a clock edge, from any state including mid-instruction; the latched opcode clears to 0 and all outputs go to 0.
REQ-028 SHALL remain in RST while `clear`=0, regardless of clock activity.

Verification
REQ-029 Bench SHALL cover: `IR`=0x52000000 (or), `Stop`=0 -> T0..T5 with strobes per REQ-012..017 (ALUop=01010 in T4 only), then T0, Run=1 throughout.
REQ-030 Bench SHALL cover: `IR`=0x70000000 (mul) -> LOin in T5, HIin in T6, ALUop=01110 in T4, 7 cycles T0..T6.
REQ-031 Bench SHALL cover: `IR`=0x80000000 (neg) -> 5 cycles; Zin with ALUop=10000 in T3, Rin in T4.
REQ-032 Bench SHALL cover: `IR`=0xC8000000 (halt) -> HALT after T2, Run=0, all strobes 0 for 10 subsequent clocks.
REQ-033 Bench SHALL cover: `Stop`=1 pulsed during T3 of an add, then `Stop`=1 at end of instruction -> only the end-of-instruction sample takes effect; HALT entered, no T0.
REQ-034 Bench SHALL cover: `clear`=0 asserted mid-T4, between clock edges -> outputs 0 and Run=0 immediately; after release, T0 on the first rising edge.
REQ-035 Bench SHALL cover: `IR`=0xF8000000 (undefined opcode) -> T2 followed by T0, with no Rin/Zin/ALUop activity.

Source files
------------

// File: rtl/control_sequencer.sv
// Hard-wired control unit. Sequences fetch (T0..T2) and execute (T3..T6) steps
// and decodes Moore-style datapath strobes from the state and latched opcode.
module control_sequencer (
   input  logic        clock,
   input  logic        clear,
   input  logic [31:0] IR,
   input  logic        Stop,
   output logic        PCout,
   output logic        IncPC,
   output logic        PCin,
   output logic        MARin,
   output logic        Zin,
   output logic        Zlowout,
   output logic        Zhighout,
   output logic        Read,
   output logic        MDRin,
   output logic        MDRout,
   output logic        IRin,
   output logic        Yin,
   output logic        LOin,
   output logic        HIin,
   output logic        Gra,
   output logic        Grb,
   output logic        Grc,
   output logic        Rin,
   output logic        Rout,
   output logic [4:0]  ALUop,
   output logic        Run
);

   typedef enum logic [3:0] {
      S_RST, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_HALT
   } state_t;

   localparam logic [4:0] OP_ADD  = 5'b00011;
   localparam logic [4:0] OP_OR   = 5'b01010;
   localparam logic [4:0] OP_MUL  = 5'b01110;
   localparam logic [4:0] OP_DIV  = 5'b01111;
   localparam logic [4:0] OP_NEG  = 5'b10000;
   localparam logic [4:0] OP_NOT  = 5'b10001;
   localparam logic [4:0] OP_HALT = 5'b11001;

   state_t     state_q, state_d;
   logic [4:0] opcode_q, opcode_d;
   logic       eoi;
   logic       unused_ir_bits;

   assign unused_ir_bits = ^IR[26:0];

   function automatic logic is_binop(input logic [4:0] op);
      return (op >= OP_ADD) && (op <= OP_OR);
   endfunction

   function automatic logic is_muldiv(input logic [4:0] op);
      return (op == OP_MUL) || (op == OP_DIV);
   endfunction

   function automatic logic is_unary(input logic [4:0] op);
      return (op == OP_NEG) || (op == OP_NOT);
   endfunction

   always_ff @(posedge clock or negedge clear) begin
      if (!clear) begin
         state_q  <= S_RST;
         opcode_q <= 5'd0;
      end else begin
         state_q  <= state_d;
         opcode_q <= opcode_d;
      end
   end

   // The T2 branch looks at IR directly because the opcode is latched on that same edge.
   always_comb begin
      state_d  = state_q;
      opcode_d = opcode_q;
      eoi      = 1'b0;
      case (state_q)
         S_RST:  state_d = S_T0;
         S_T0:   state_d = S_T1;
         S_T1:   state_d = S_T2;
         S_T2: begin
            opcode_d = IR[31:27];
            if (IR[31:27] == OP_HALT)
               state_d = S_HALT;
            else if (is_binop(IR[31:27]) || is_muldiv(IR[31:27]) || is_unary(IR[31:27]))
               state_d = S_T3;
            else
               eoi = 1'b1;
         end
         S_T3:   state_d = S_T4;
         S_T4: begin
            if (is_unary(opcode_q)) eoi = 1'b1;
            else                    state_d = S_T5;
         end
         S_T5: begin
            if (is_muldiv(opcode_q)) state_d = S_T6;
            else                     eoi = 1'b1;
         end
         S_T6:   eoi = 1'b1;
         S_HALT: state_d = S_HALT;
         default: state_d = S_RST;
      endcase
      if (eoi) state_d = Stop ? S_HALT : S_T0;
   end

   always_comb begin
      PCout    = 1'b0;
      IncPC    = 1'b0;
      PCin     = 1'b0;
      MARin    = 1'b0;
      Zin      = 1'b0;
      Zlowout  = 1'b0;
      Zhighout = 1'b0;
      Read     = 1'b0;
      MDRin    = 1'b0;
      MDRout   = 1'b0;
      IRin     = 1'b0;
      Yin      = 1'b0;
      LOin     = 1'b0;
      HIin     = 1'b0;
      Gra      = 1'b0;
      Grb      = 1'b0;
      Grc      = 1'b0;
      Rin      = 1'b0;
      Rout     = 1'b0;
      ALUop    = 5'd0;
      Run      = (state_q != S_RST) && (state_q != S_HALT);
      case (state_q)
         S_T0: begin
            PCout = 1'b1; IncPC = 1'b1; Zin = 1'b1; MARin = 1'b1;
         end
         S_T1: begin
            Zlowout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1;
         end
         S_T2: begin
            MDRout = 1'b1; IRin = 1'b1;
         end
         S_T3: begin
            Grb = 1'b1; Rout = 1'b1;
            if (is_unary(opcode_q)) begin
               Zin = 1'b1; ALUop = opcode_q;
            end else begin
               Yin = 1'b1;
            end
         end
         S_T4: begin
            if (is_unary(opcode_q)) begin
               Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1;
            end else begin
               Grc = 1'b1; Rout = 1'b1; Zin = 1'b1; ALUop = opcode_q;
            end
         end
         S_T5: begin
            Zlowout = 1'b1;
            if (is_muldiv(opcode_q)) LOin = 1'b1;
            else begin
               Gra = 1'b1; Rin = 1'b1;
            end
         end
         S_T6: begin
            Zhighout = 1'b1; HIin = 1'b1;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: directed table, hand-written corner sequences and
// random instructions, all checked against a step-list reference model.
module tb_control_sequencer;

   logic        clock = 1'b0;
   logic        clear;
   logic [31:0] IR;
   logic        Stop;
   logic        PCout, IncPC, PCin, MARin, Zin, Zlowout, Zhighout, Read, MDRin;
   logic        MDRout, IRin, Yin, LOin, HIin, Gra, Grb, Grc, Rin, Rout, Run;
   logic [4:0]  ALUop;

   always #5 clock = ~clock;

   control_sequencer dut (
      .clock(clock), .clear(clear), .IR(IR), .Stop(Stop),
      .PCout(PCout), .IncPC(IncPC), .PCin(PCin), .MARin(MARin), .Zin(Zin),
      .Zlowout(Zlowout), .Zhighout(Zhighout), .Read(Read), .MDRin(MDRin),
      .MDRout(MDRout), .IRin(IRin), .Yin(Yin), .LOin(LOin), .HIin(HIin),
      .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout),
      .ALUop(ALUop), .Run(Run)
   );

   logic [24:0] dut_v;
   assign dut_v = {PCout, IncPC, PCin, MARin, Zin, Zlowout, Zhighout, Read, MDRin,
                   MDRout, IRin, Yin, LOin, HIin, Gra, Grb, Grc, Rin, Rout, Run, ALUop};

   localparam logic [24:0] PCO = 25'h1 << 24, INC = 25'h1 << 23, PCI = 25'h1 << 22;
   localparam logic [24:0] MAR = 25'h1 << 21, ZIN = 25'h1 << 20, ZLO = 25'h1 << 19;
   localparam logic [24:0] ZHI = 25'h1 << 18, RD  = 25'h1 << 17, MDI = 25'h1 << 16;
   localparam logic [24:0] MDO = 25'h1 << 15, IRI = 25'h1 << 14, YIN = 25'h1 << 13;
   localparam logic [24:0] LOI = 25'h1 << 12, HII = 25'h1 << 11, GRA = 25'h1 << 10;
   localparam logic [24:0] GRB = 25'h1 << 9,  GRC = 25'h1 << 8,  RIN = 25'h1 << 7;
   localparam logic [24:0] ROU = 25'h1 << 6,  RUN = 25'h1 << 5;
   localparam logic [24:0] T0_V = RUN | PCO | INC | ZIN | MAR;

   typedef struct {
      string       name;
      logic [31:0] ir;
      logic        stop;
      int          cycles;
      logic        halt;
   } vec_t;

   int          vectors = 0;
   int          miscompares = 0;
   logic [24:0] exp_q[$];

   // Reference: list of strobe sets the instruction should produce, one per clock.
   function automatic void build(input logic [31:0] ir);
      logic [4:0]  op;
      logic [24:0] alu;
      op  = ir[31:27];
      alu = {20'h0, op};
      exp_q.delete();
      exp_q.push_back(T0_V);
      exp_q.push_back(RUN | ZLO | PCI | RD | MDI);
      exp_q.push_back(RUN | MDO | IRI);
      if ((op >= 5'd3 && op <= 5'd10) || op == 5'd14 || op == 5'd15) begin
         exp_q.push_back(RUN | GRB | ROU | YIN);
         exp_q.push_back(RUN | GRC | ROU | ZIN | alu);
         if (op >= 5'd14) begin
            exp_q.push_back(RUN | ZLO | LOI);
            exp_q.push_back(RUN | ZHI | HII);
         end else begin
            exp_q.push_back(RUN | ZLO | GRA | RIN);
         end
      end else if (op == 5'd16 || op == 5'd17) begin
         exp_q.push_back(RUN | GRB | ROU | ZIN | alu);
         exp_q.push_back(RUN | ZLO | GRA | RIN);
      end
   endfunction

   task automatic chk(input string nm, input logic [24:0] got, input logic [24:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", nm, got, exp);
      end
   endtask

   // Entered just after a falling edge; drops clear between edges.
   task automatic do_reset();
      #2 clear = 1'b0;
      #1 chk("clear_async", dut_v, 25'h0);
      @(posedge clock); @(negedge clock);
      chk("clear_hold", dut_v, 25'h0);
      clear = 1'b1;
      @(posedge clock); @(negedge clock);
   endtask

   // mid: 0 Stop low mid-instruction, 1 random Stop, 2 Stop pulsed in T3 only.
   task automatic exec(input string nm, input logic [31:0] ir, input logic stop_end,
                       input int mid, input int cycles, input logic halt);
      build(ir);
      for (int i = 0; i < cycles; i++) begin
         IR = (i == 2) ? ir : $urandom;
         if (i == cycles - 1) Stop = stop_end;
         else if (mid == 1)   Stop = 1'($urandom_range(0, 1));
         else if (mid == 2)   Stop = (i == 3);
         else                 Stop = 1'b0;
         chk($sformatf("%s_step%0d", nm, i), dut_v,
             (i < exp_q.size()) ? exp_q[i] : 25'h0);
         @(posedge clock); @(negedge clock);
      end
      Stop = 1'b0;
      if (halt) begin
         for (int k = 0; k <= 10; k++) begin
            Stop = 1'($urandom_range(0, 1));
            chk($sformatf("%s_halt%0d", nm, k), dut_v, 25'h0);
            @(posedge clock); @(negedge clock);
         end
         Stop = 1'b0;
         do_reset();
      end else begin
         chk($sformatf("%s_next_t0", nm), dut_v, T0_V);
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      vec_t        tbl[10];
      logic [4:0]  ops[14];
      logic [4:0]  op;
      logic [31:0] ir;
      logic        st;

      tbl[0] = '{"or",    32'h52000000, 1'b0, 6, 1'b0};
      tbl[1] = '{"mul",   32'h70000000, 1'b0, 7, 1'b0};
      tbl[2] = '{"neg",   32'h80000000, 1'b0, 5, 1'b0};
      tbl[3] = '{"halt",  32'hC8000000, 1'b0, 3, 1'b1};
      tbl[4] = '{"undef", 32'hF8000000, 1'b0, 3, 1'b0};
      tbl[5] = '{"nop_st",32'hC0000000, 1'b1, 3, 1'b1};
      tbl[6] = '{"div_st",32'h78000000, 1'b1, 7, 1'b1};
      tbl[7] = '{"not",   32'h88000000, 1'b0, 5, 1'b0};
      tbl[8] = '{"add",   32'h18000000, 1'b0, 6, 1'b0};
      tbl[9] = '{"shl",   32'h30000000, 1'b0, 6, 1'b0};
      ops = '{5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd10,
              5'd14, 5'd15, 5'd16, 5'd17, 5'd24, 5'd25};

      clear = 1'b0; IR = 32'h0; Stop = 1'b0;
      repeat (3) @(posedge clock);
      @(negedge clock);
      chk("reset_state", dut_v, 25'h0);
      clear = 1'b1;
      @(posedge clock); @(negedge clock);

      foreach (tbl[i])
         exec(tbl[i].name, tbl[i].ir, tbl[i].stop, 0, tbl[i].cycles, tbl[i].halt);

      // Stop pulsed across the T3 edge must be ignored; only the final sample halts.
      exec("add_stop", 32'h18000000, 1'b1, 2, 6, 1'b1);

      // Clear dropped between edges while in T4.
      build(32'h18000000);
      for (int i = 0; i < 4; i++) begin
         IR = (i == 2) ? 32'h18000000 : $urandom;
         chk($sformatf("clr_t4_step%0d", i), dut_v, exp_q[i]);
         @(posedge clock); @(negedge clock);
      end
      chk("clr_t4_in_t4", dut_v, exp_q[4]);
      do_reset();
      chk("clr_t4_first_t0", dut_v, T0_V);

      for (int n = 0; n < 150; n++) begin
         if ($urandom_range(0, 4) == 0) op = 5'($urandom);
         else                          op = ops[$urandom_range(0, 13)];
         ir = {op, 27'($urandom)};
         st = ($urandom_range(0, 7) == 0);
         build(ir);
         exec($sformatf("rnd%0d", n), ir, st, 1, exp_q.size(), st || (op == 5'd25));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
